// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS fetch stage: PC register, imem handshake, next-PC select
// Optional jump-register alignment trap: FETCH_MISALIGN_TRAP_EN
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_addr,
    input  logic [31:0] jr_target,
    input  logic        advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic [31:0] next_pc;
    logic [31:0] branch_off;
    logic        jr_trap;

    assign pc_plus4   = pc_q + 32'd4;
    assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            2'b00: next_pc = pc_plus4;
            2'b01: next_pc = pc_plus4 + branch_off;
            2'b10: next_pc = {pc_plus4[31:28], jump_addr, 2'b00};
            2'b11: next_pc = jr_target & 32'hFFFF_FFFC;
            default: next_pc = pc_plus4;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign jr_trap = (pc_sel == 2'b11) && (jr_target[1:0] != 2'b00);
`else
    assign jr_trap = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (advance) begin
                    // A trapped jump-register keeps pc pointing at the offending jr
                    if (jr_trap) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d    = next_pc;
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Request is decoded from state so an async reset drops it without a clock edge
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign misalign    = misalign_q;

endmodule
